// File: rtl/ofdm_cp_remove.sv
// OFDM cyclic-prefix remover and FFT framer.
// Drops the CP_LEN prefix samples that follow a start-of-symbol marker and
// buffers the next NFFT samples. When the FFT reports it is waiting for data,
// those samples are replayed as one gap-free frame with valid held high.
module ofdm_cp_remove #(
    parameter int SIZE_BUFFER = 8,
    parameter int DATA_SIZE   = 16,
    parameter int CP_LEN      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    output logic                 in_ready,
    input  logic                 fft_wayt_data,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] data_out_i,
    output logic [DATA_SIZE-1:0] data_out_q,
    output logic [2:0]           state,
    output logic                 sync_err,
    output logic                 drop
);

    localparam int NFFT = 2 ** SIZE_BUFFER;
    localparam int CW   = SIZE_BUFFER + 1;
    localparam logic [CW-1:0] CP_CNT   = CW'(CP_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(NFFT - 1);
    localparam logic [CW-1:0] NFFT_CNT = CW'(NFFT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SKIP_CP  = 3'd1,
        CAPTURE  = 3'd2,
        WAIT_FFT = 3'd3,
        BURST    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   syncErr_q, syncErr_d;
    logic                   drop_q, drop_d;
    logic                   rdValid_q;
    logic [2*DATA_SIZE-1:0] rdData_q;
    logic                   valid_q;
    logic [2*DATA_SIZE-1:0] dataOut_q;

    logic [2*DATA_SIZE-1:0] mem [NFFT];
    logic                   memWe;
    logic                   memRe;
    logic [SIZE_BUFFER-1:0] memAddr;
    logic                   accepted;
    logic                   sofAccepted;

    // Input is taken only while receiving; waiting and bursting refuse it.
    assign in_ready    = (state_q == IDLE) || (state_q == SKIP_CP) || (state_q == CAPTURE);
    assign accepted    = in_valid & in_ready;
    assign sofAccepted = accepted & in_sof;

    // Next-state logic; a marker in any receiving state starts a fresh symbol.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        memWe     = 1'b0;
        memRe     = 1'b0;
        memAddr   = cnt_q[SIZE_BUFFER-1:0];
        syncErr_d = 1'b0;
        drop_d    = in_valid & ~in_ready;
        if (sofAccepted) begin
            syncErr_d = (state_q != IDLE);
            cnt_d     = CW'(1);
            if (CP_LEN == 0) begin
                memWe   = 1'b1;
                memAddr = '0;
                state_d = CAPTURE;
            end else begin
                state_d = SKIP_CP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                SKIP_CP: begin
                    if (accepted) begin
                        if (cnt_q == CP_CNT) begin
                            memWe   = 1'b1;
                            memAddr = '0;
                            cnt_d   = CW'(1);
                            state_d = CAPTURE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (accepted) begin
                        memWe = 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = '0;
                            state_d = WAIT_FFT;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                WAIT_FFT: begin
                    if (fft_wayt_data) begin
                        cnt_d   = '0;
                        state_d = BURST;
                    end
                end
                BURST: begin
                    if (cnt_q != NFFT_CNT) begin
                        memRe = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end else if (!rdValid_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sample buffer; writes and reads never coincide so one port suffices.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= {in_data_i, in_data_q};
        end
        if (memRe) begin
            rdData_q <= mem[memAddr];
        end
    end

    // Control registers and the output stage one cycle behind the buffer read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            syncErr_q <= 1'b0;
            drop_q    <= 1'b0;
            rdValid_q <= 1'b0;
            valid_q   <= 1'b0;
            dataOut_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            syncErr_q <= syncErr_d;
            drop_q    <= drop_d;
            rdValid_q <= memRe;
            valid_q   <= rdValid_q;
            if (rdValid_q) begin
                dataOut_q <= rdData_q;
            end
        end
    end

    assign state      = state_q;
    assign valid      = valid_q;
    assign data_out_i = dataOut_q[2*DATA_SIZE-1:DATA_SIZE];
    assign data_out_q = dataOut_q[DATA_SIZE-1:0];
    assign sync_err   = syncErr_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Bench for ofdm_cp_remove: directed symbols, scoreboard of expected frames.
module tb_ofdm_cp_remove;

    localparam int SB   = 4;
    localparam int DW   = 16;
    localparam int CP   = 4;
    localparam int NFFT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inValid = 1'b0;
    logic          inSof = 1'b0;
    logic          fftWayt = 1'b0;
    logic [DW-1:0] inI = '0;
    logic [DW-1:0] inQ = '0;

    logic          inReady, valid, syncErr, drop;
    logic [DW-1:0] outI, outQ;
    logic [2:0]    state;
    logic          inReady0, valid0, syncErr0, drop0;
    logic [DW-1:0] outI0, outQ0;
    logic [2:0]    state0;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int dropCnt = 0;
    int syncCnt = 0;
    int expDrops = 0;
    int expSync = 0;
    int runLen = 0;
    int pop0 = 0;
    int sinceSof = -1;
    bit modelReady = 1'b1;
    bit mon0En = 1'b0;
    logic [31:0] expQ[$];
    logic [31:0] expQ0[$];
    logic [31:0] stage[$];

    ofdm_cp_remove #(.SIZE_BUFFER(SB), .DATA_SIZE(DW), .CP_LEN(CP)) dut (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_sof(inSof),
        .in_data_i(inI), .in_data_q(inQ), .in_ready(inReady),
        .fft_wayt_data(fftWayt), .valid(valid), .data_out_i(outI),
        .data_out_q(outQ), .state(state), .sync_err(syncErr), .drop(drop)
    );

    ofdm_cp_remove #(.SIZE_BUFFER(SB), .DATA_SIZE(DW), .CP_LEN(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_sof(inSof),
        .in_data_i(inI), .in_data_q(inQ), .in_ready(inReady0),
        .fft_wayt_data(fftWayt), .valid(valid0), .data_out_i(outI0),
        .data_out_q(outQ0), .state(state0), .sync_err(syncErr0), .drop(drop0)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of input and advances the reference model of the framer.
    task automatic applyStimulus(input bit v, input bit sof, input int k);
        @(negedge clk);
        inValid = v;
        inSof   = sof;
        inI     = DW'(k);
        inQ     = DW'(-k);
        if (v) checkOutput("inReady", 32'(inReady), 32'(modelReady));
        @(posedge clk);
        if (v) begin
            if (!modelReady) begin
                expDrops++;
            end else begin
                if (sof) begin
                    if (sinceSof >= 0) expSync++;
                    stage.delete();
                    sinceSof = 0;
                end
                if (sinceSof >= 0) begin
                    if (sinceSof >= CP) stage.push_back({inI, inQ});
                    sinceSof++;
                    if (stage.size() == NFFT) begin
                        foreach (stage[i]) expQ.push_back(stage[i]);
                        stage.delete();
                        modelReady = 1'b0;
                        sinceSof   = -1;
                    end
                end
            end
        end
    endtask

    // Streams a symbol of n samples starting at value base, marker on the first.
    task automatic sendSymbol(input int base, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, i == 0, base + i);
        @(negedge clk);
        inValid = 1'b0;
        inSof   = 1'b0;
    endtask

    // Synchronous reset of both instances, with the reset state checked.
    task automatic applyReset();
        @(negedge clk);
        reset   = 1'b1;
        inValid = 1'b0;
        inSof   = 1'b0;
        fftWayt = 1'b0;
        @(negedge clk);
        checkOutput("rstState", 32'(state), 32'd0);
        checkOutput("rstValid", 32'(valid), 32'd0);
        checkOutput("rstInReady", 32'(inReady), 32'd1);
        checkOutput("rstData", {outI, outQ}, 32'd0);
        checkOutput("rstSyncErr", 32'(syncErr), 32'd0);
        checkOutput("rstDrop", 32'(drop), 32'd0);
        reset = 1'b0;
        expQ.delete();
        stage.delete();
        sinceSof   = -1;
        modelReady = 1'b1;
    endtask

    // Releases the FFT handshake and follows the whole burst to its end.
    task automatic runBurst();
        int n;
        checkOutput("waitState", 32'(state), 32'd3);
        @(negedge clk);
        inValid = 1'b0;
        fftWayt = 1'b1;
        @(negedge clk);
        fftWayt = 1'b0;
        checkOutput("burstState", 32'(state), 32'd4);
        checkOutput("validLat0", 32'(valid), 32'd0);
        @(negedge clk);
        checkOutput("validLat1", 32'(valid), 32'd0);
        @(negedge clk);
        checkOutput("validLat2", 32'(valid), 32'd1);
        n = 0;
        while (valid === 1'b1 && n < 4 * NFFT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("burstEnds", 32'(n < 4 * NFFT), 32'd1);
        checkOutput("stateAfterBurst", 32'(state), 32'd0);
        checkOutput("frameComplete", 32'(expQ.size()), 32'd0);
        modelReady = 1'b1;
    endtask

    // Output monitor: pops expected samples and checks frame length and pulses.
    always begin
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (reset) begin
            runLen = 0;
        end else begin
            if (drop) dropCnt++;
            if (syncErr) syncCnt++;
            if (valid) begin
                runLen++;
                if (expQ.size() != 0) e = expQ.pop_front();
                else e = 'x;
                checkOutput("frameData", {outI, outQ}, e);
            end else if (runLen != 0) begin
                checkOutput("frameLen", 32'(runLen), 32'(NFFT));
                runLen = 0;
            end
            if (mon0En && valid0) begin
                pop0++;
                if (expQ0.size() != 0) e = expQ0.pop_front();
                else e = 'x;
                checkOutput("frame0Data", {outI0, outQ0}, e);
            end
        end
    end

    // Directed test sequence.
    initial begin
        int k;
        int c;
        int n;
        int base;

        applyReset();

        $display("[TB] nominal symbol");
        sendSymbol(0, 20);
        runBurst();
        checkOutput("nominalSync", 32'(syncCnt), 32'(expSync));

        $display("[TB] gapped input");
        k = 0;
        c = 0;
        while (k < 20) begin
            if (c % 3 == 2) applyStimulus(1'b0, 1'b0, 0);
            else begin
                applyStimulus(1'b1, k == 0, k);
                k++;
            end
            c++;
        end
        @(negedge clk);
        inValid = 1'b0;
        runBurst();
        checkOutput("gapDrops", 32'(dropCnt), 32'(expDrops));
        checkOutput("gapSync", 32'(syncCnt), 32'(expSync));

        $display("[TB] backpressure");
        sendSymbol(0, 20);
        base = dropCnt;
        for (int i = 0; i < 30; i++) applyStimulus(i < 5, 1'b0, 50 + i);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("bpState", 32'(state), 32'd3);
        checkOutput("bpDropDelta", 32'(dropCnt - base), 32'd5);
        checkOutput("bpDrops", 32'(dropCnt), 32'(expDrops));
        runBurst();

        $display("[TB] resync");
        base = syncCnt;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, (i == 0) || (i == 10), i);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("resyncDelta", 32'(syncCnt - base), 32'd1);
        checkOutput("resyncSync", 32'(syncCnt), 32'(expSync));
        runBurst();

        $display("[TB] reset during burst");
        sendSymbol(100, 20);
        checkOutput("preRstState", 32'(state), 32'd3);
        @(negedge clk);
        fftWayt = 1'b1;
        @(negedge clk);
        fftWayt = 1'b0;
        n = 0;
        while (expQ.size() > NFFT - 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midBurstReached", 32'(n < 40), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", 32'(valid), 32'd0);
        checkOutput("midRstState", 32'(state), 32'd0);
        reset = 1'b0;
        expQ.delete();
        stage.delete();
        sinceSof   = -1;
        modelReady = 1'b1;
        sendSymbol(200, 20);
        runBurst();

        $display("[TB] zero-length prefix");
        applyReset();
        mon0En = 1'b1;
        pop0   = 0;
        for (int i = 0; i < NFFT; i++) begin
            applyStimulus(1'b1, i == 0, 7 + i);
            expQ0.push_back({DW'(7 + i), DW'(-(7 + i))});
        end
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("cp0Wait", 32'(state0), 32'd3);
        fftWayt = 1'b1;
        @(negedge clk);
        fftWayt = 1'b0;
        n = 0;
        while (!(pop0 == NFFT && valid0 === 1'b0) && n < 4 * NFFT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cp0Count", 32'(pop0), 32'(NFFT));
        checkOutput("cp0Empty", 32'(expQ0.size()), 32'd0);
        checkOutput("cp0State", 32'(state0), 32'd0);
        checkOutput("cp0MainState", 32'(state), 32'd2);
        mon0En = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
